// File: rtl/clk_div_pkg.sv
// Shared constants and configuration clamping for the programmable clock divider.
package clk_div_pkg;

  localparam int DIV_WIDTH   = 16;
  localparam int DIV_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] div_eff;
    logic [31:0] high_eff;
  } clamp_t;

  // Divisor is floored at 2 and high-time kept inside 1..div-1 so every enabled channel toggles.
  function automatic clamp_t clamp_cfg(input logic [31:0] div, input logic [31:0] high);
    clamp_t r;
    r.div_eff = (div < 32'd2) ? 32'd2 : div;
    if (high == 32'd0)
      r.high_eff = 32'd1;
    else if (high >= r.div_eff)
      r.high_eff = r.div_eff - 32'd1;
    else
      r.high_eff = high;
    return r;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/pending config and registered outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = DIV_WIDTH,
  parameter int DEFAULT_DIV = DIV_DEFAULT
) (
  input  logic             old_clock,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
  output logic             new_clock,
  output logic             tick,
  output logic             pending
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] high_act;
  logic [WIDTH-1:0] div_pend;
  logic [WIDTH-1:0] high_pend;
  logic             last;
  logic             wrap;
  logic             apply;
  clamp_t           eff;
  logic [WIDTH-1:0] div_eff;
  logic [WIDTH-1:0] high_eff;

  assign last     = (cnt == div_act - WIDTH'(1));
  // Sync truncates the period without counting as a wrap, so it never applies config.
  assign wrap     = en && !sync && last;
  assign apply    = pending && (!en || wrap);
  assign eff      = clamp_cfg(32'(div_pend), 32'(high_pend));
  assign div_eff  = WIDTH'(eff.div_eff);
  assign high_eff = WIDTH'(eff.high_eff);

  always_ff @(posedge old_clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      div_act   <= WIDTH'(DEFAULT_DIV);
      high_act  <= WIDTH'(DEFAULT_DIV / 2);
      div_pend  <= '0;
      high_pend <= '0;
      pending   <= 1'b0;
      new_clock <= 1'b0;
      tick      <= 1'b0;
    end else begin
      new_clock <= en && (cnt < high_act);
      tick      <= en && last;

      if (!en || sync || last)
        cnt <= '0;
      else
        cnt <= cnt + WIDTH'(1);

      if (apply) begin
        div_act  <= div_eff;
        high_act <= high_eff;
      end

      // A load on the apply cycle is captured after the old pending values move out.
      if (load) begin
        div_pend  <= div_in;
        high_pend <= high_in;
        pending   <= 1'b1;
      end else if (apply) begin
        pending   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: one clk_div_chan per channel sharing sync.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = DIV_WIDTH,
  parameter int DEFAULT_DIV = DIV_DEFAULT
) (
  input  logic                      old_clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en,
  input  logic                      sync,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] div_in,
  input  logic [CHANNELS*WIDTH-1:0] high_in,
  output logic [CHANNELS-1:0]       new_clock,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       pending
);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    clk_div_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .old_clock (old_clock),
      .reset     (reset),
      .en        (en[k]),
      .sync      (sync),
      .load      (load[k]),
      .div_in    (div_in[k*WIDTH +: WIDTH]),
      .high_in   (high_in[k*WIDTH +: WIDTH]),
      .new_clock (new_clock[k]),
      .tick      (tick[k]),
      .pending   (pending[k])
    );
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Multi-channel, runtime-programmable clock divider. Generation after the fixed-ratio divider.
- Each channel derives a divided clock and a one-cycle wrap strobe from one source clock.
- Divisor and high-time are programmable per channel. Updates are glitch-free and take effect only at a period boundary.
- Sits beside the system clock source. Feeds slow peripherals, baud generators and sample strobes.

Parameters:
- CHANNELS, 2: number of independent divider channels.
- WIDTH, 16: bit width of each channel's counter, divisor and high-time.
- DEFAULT_DIV, 4: divisor loaded into every channel at reset (must be >= 2).

Ports:
- old_clock  input  1  source clock to be divided.
- reset  input  1  asynchronous, active-high reset.
- en  input  CHANNELS  per-channel run enable.
- sync  input  1  single-cycle pulse; realigns all channel counters to 0.
- load  input  CHANNELS  per-channel config capture strobe.
- div_in  input  CHANNELS*WIDTH  requested divisor; channel k occupies bits [k*WIDTH +: WIDTH].
- high_in  input  CHANNELS*WIDTH  requested high-time in source cycles; same packing as div_in.
- new_clock  output  CHANNELS  registered divided clocks.
- tick  output  CHANNELS  one-cycle strobe on the last source cycle of each period.
- pending  output  CHANNELS  high while a captured config waits to be applied.

Behaviour:
- Reset (async assert, release on the next edge of old_clock):
  - cnt=0, div_act=DEFAULT_DIV, high_act=DEFAULT_DIV/2.
  - Pending registers cleared.
  - new_clock=0, tick=0, pending=0.
- Effective config (clamp, applied when a value is moved into the active registers):
  - div_eff = max(div, 2).
  - high_eff = 1 if high=0; div_eff-1 if high >= div_eff; otherwise high.
  - Every enabled channel therefore always toggles. No bypass mode.
- Counter:
  - cnt runs 0..div_act-1, then wraps to 0.
  - The wrap cycle is the cycle with cnt == div_act-1.
- Outputs (both registered, one cycle after the cnt value they are derived from):
  - new_clock[k] <= en[k] && (cnt < high_act).
  - tick[k] <= en[k] && (cnt == div_act-1).
  - Result: high for high_act cycles, low for div_act-high_act cycles, period div_act.
- Config capture and apply:
  - load[k]=1 captures div_in/high_in into pending registers and sets pending[k].
  - Another load before apply overwrites the pending values (last wins).
  - Apply happens on the wrap cycle, or immediately while en[k]=0. Apply copies the clamped pending values to the active registers and clears pending[k].
  - Load coincident with the wrap cycle: the old pending values (if any) apply. The new values are captured and apply at the following wrap.
  - Load and apply in the same cycle: pending[k] stays 1.
- Enable:
  - en[k]=0: cnt held 0, new_clock[k] and tick[k] forced 0 on the next cycle.
  - Rising en[k]: counting starts from cnt=0. The first new_clock high appears one cycle later.
- Sync:
  - Forces cnt=0 in all enabled channels on the next edge, so every new_clock restarts its high phase together.
  - No tick is generated for the truncated period.
  - Sync does not count as a wrap, so it does not apply pending config.
- Priority per channel: reset > !en > sync > wrap > increment.
- Reset mid-period: abandons the period immediately; new_clock drops asynchronously with reset.
- Arithmetic: all compares are unsigned at WIDTH bits. cnt never exceeds div_act-1, because div_act only changes at wrap or while disabled.

Decomposition:
- Package clk_div_pkg holds:
  - the WIDTH default constant;
  - the DEFAULT_DIV constant;
  - a clamp function returning div_eff/high_eff.
- Sub-module clk_div_chan holds one channel's counter, active/pending registers and output flops.
- clk_div_prog generates CHANNELS instances of clk_div_chan, slices the packed buses and fans out sync.

Test Plan:
- Reset defaults: reset high, then released with en=01 and DEFAULT_DIV=4 -> ch0 new_clock follows 1100 repeating, starting one cycle after en; tick on every 4th cycle, coincident with the second low cycle; ch1 stays 0.
- Glitch-free reload: ch0 running div=4/high=2; load div=6/high=3 mid-period -> pending=1 until the wrap; the current period completes as 1100; then 111000 repeating and pending=0.
- Clamping: load div=1/high=0 while disabled, then enable -> behaves as div=2/high=1 (1010 pattern). Load div=5/high=9 -> 11110 pattern.
- Load on the wrap cycle: with a prior pending div=8, load div=3 exactly on the wrap cycle -> the div=8 period runs next, then div=3; pending falls only after the second apply.
- Sync alignment: ch0 div=4 and ch1 div=6 at arbitrary phases; pulse sync -> both new_clock rise on the same cycle after sync; no tick for the truncated periods.
- Disable and async reset: drop en[0] mid-high -> new_clock[0]=0 next cycle, cnt=0; assert reset between clock edges -> all outputs 0 immediately, without waiting for an edge.
